// File: rtl/button_debounce_pkg.sv
// Board-level constants for the Nexys3 push-button path.
package nexys3_defs;

   localparam int unsigned CLK_FREQ_HZ = 100000000;
   localparam int unsigned NUM_BTNS    = 5;

   // Converts a time in milliseconds to a number of system clock cycles.
   function automatic int unsigned ms_to_cycles(input int unsigned ms);
      return (CLK_FREQ_HZ / 1000) * ms;
   endfunction

   // Stability window used for mechanical buttons: 10 ms.
   localparam int unsigned DEBOUNCE_10MS = ms_to_cycles(10);

endpackage

// File: rtl/button_debounce_cell.sv
// One button channel: two-flop synchroniser, stability counter, debounced level and
// one-cycle press/release pulses. DEBOUNCE_CYCLES must be at least 2.
module debounce_cell
   import nexys3_defs::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_in,
   output logic btn_level,
   output logic btn_rise,
   output logic btn_fall
);

   localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_s1;
   logic             r_s2;
   logic [CNT_W-1:0] r_cnt;
   logic             r_level;
   logic             r_rise;
   logic             r_fall;

   logic w_differ;
   logic w_done;

   // Settling while the synchronised input disagrees with the held level.
   assign w_differ = r_s2 ^ r_level;
   assign w_done   = w_differ && (r_cnt == CNT_MAX);

   // Two-flop synchroniser; r_s1 absorbs metastability, only r_s2 is used.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= btn_in;
         r_s2 <= r_s1;
      end
   end

   // Stability counter with level update and edge pulses on the final count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
         if (w_done) begin
            r_level <= r_s2;
            r_cnt   <= '0;
            r_rise  <= r_s2;
            r_fall  <= ~r_s2;
         end else if (w_differ) begin
            r_cnt <= r_cnt + 1'b1;
         end else begin
            // Input agrees with level again: discard any partial count.
            r_cnt <= '0;
         end
      end
   end

   assign btn_level = r_level;
   assign btn_rise  = r_rise;
   assign btn_fall  = r_fall;

endmodule

// File: rtl/button_debounce.sv
// Multi-channel push-button conditioner: one independent debounce cell per button.
module button_debounce
   import nexys3_defs::*;
#(
   parameter int unsigned WIDTH           = NUM_BTNS,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] btn_in,
   output logic [WIDTH-1:0] btn_level,
   output logic [WIDTH-1:0] btn_rise,
   output logic [WIDTH-1:0] btn_fall
);

   // One cell per channel; channels share nothing but clock and reset.
   for (genvar g = 0; g < WIDTH; g++) begin : g_chan
      debounce_cell #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_cell (
         .clk      (clk),
         .reset_n  (reset_n),
         .btn_in   (btn_in[g]),
         .btn_level(btn_level[g]),
         .btn_rise (btn_rise[g]),
         .btn_fall (btn_fall[g])
      );
   end

endmodule

// File: doc/button_debounce.md
# button_debounce

Multi-channel push-button conditioner that sits directly upstream of `system` on the Nexys3 board. It sits between the raw `btns` pins and the logic that consumes them. Each asynchronous, bouncing button input passes through a two-flop synchroniser and a per-channel debounce counter. Each channel produces a clean level plus one-cycle press/release pulses, so `system` sees one event per physical press.

## Interface

Parameters:

- `WIDTH`, default 5: number of button channels (Nexys3 has 5 push buttons).
- `DEBOUNCE_CYCLES`, default 1000000: stability window in `clk` cycles (10 ms at 100 MHz). Must be ≥ 2. Benches use 4.

Ports:

- `clk`, input, 1: system clock, 100 MHz on board.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `btn_in`, input, `WIDTH`: raw button pins, active-high, asynchronous to `clk`.
- `btn_level`, output, `WIDTH`: debounced button state, 1 = pressed.
- `btn_rise`, output, `WIDTH`: one-cycle pulse when `btn_level[i]` goes 0→1.
- `btn_fall`, output, `WIDTH`: one-cycle pulse when `btn_level[i]` goes 1→0.

## Operation

- Channels are fully independent. There is no shared state except `clk` and `reset_n`.
- Synchroniser per channel: `s1 <= btn_in[i]`, then `s2 <= s1`. Only `s2` is used downstream.
- Counter per channel, `cnt`, width `$clog2(DEBOUNCE_CYCLES)`. Two-state behaviour, STABLE and SETTLING, implied by `s2 == level` versus `s2 != level`:
  - `s2 == level`: `cnt <= 0`. This rejects glitches; any partial count is discarded.
  - `s2 != level` and `cnt < DEBOUNCE_CYCLES-1`: `cnt <= cnt + 1`.
  - `s2 != level` and `cnt == DEBOUNCE_CYCLES-1`: `level <= s2`, `cnt <= 0`.
- Pulses:
  - `btn_rise[i]` is registered and equals 1 for exactly the cycle in which `level` first reads 1.
  - `btn_fall[i]` is the same for `level` first reading 0.
  - Rise and fall are never asserted together on one channel.
- The counter never wraps. It saturates into the update condition.
- Reset (asynchronous assert, in any state, including mid-count):
  - `s1`, `s2`, `cnt`, `btn_level`, `btn_rise` and `btn_fall` are all cleared to 0.
  - No pulse is emitted by the reset itself.
- Button held through reset release: the channel treats this as a fresh press. `btn_level` rises and `btn_rise` pulses after the normal latency.

## Timing

- All outputs reset to 0 and are registered; there are no combinational paths from input to output.
- Latency counts rising edges, with edge 0 being the first edge after `btn_in[i]` changes and stays stable:
  - Edge 0 captures `s1`; edge 1 captures `s2`.
  - Edges 2 … `DEBOUNCE_CYCLES` count from 0 to `DEBOUNCE_CYCLES-1`.
  - Edge `DEBOUNCE_CYCLES+1` updates `btn_level` and the pulse.
  - The new level is therefore visible after `DEBOUNCE_CYCLES+2` edges.
- Rejection: any excursion of `s2` lasting fewer than `DEBOUNCE_CYCLES` cycles produces no output change.
- The minimum spacing between two pulses on a channel is `DEBOUNCE_CYCLES` cycles.
- `btn_in` has no setup requirement. Metastability is contained by `s1`.

## Structure

- Top level `button_debounce` instantiates `WIDTH` copies of one sub-module, `debounce_cell`, using a generate loop. Each cell is one channel: synchroniser, counter, level and pulse registers.
- Shared board package or header `nexys3_defs`:
  - `CLK_FREQ_HZ = 100000000`.
  - `NUM_BTNS = 5`.
  - A helper constant for the 10 ms debounce count.
- No other typedefs are required.

## Test plan

Bench configuration: `WIDTH=5`, `DEBOUNCE_CYCLES=4`, 10 ns clock.

- **Reset:** hold `reset_n=0` for 8 cycles with `btn_in=5'b11111` → all outputs 0 throughout. After release with inputs held high, `btn_level=5'b11111` and `btn_rise=5'b11111` for exactly one cycle, 6 edges later.
- **Clean press/release on channel 0:** `btn_in[0]` 0→1, held 20 cycles, then 1→0 → `btn_level[0]` rises 6 edges after the press with a single `btn_rise[0]` pulse. `btn_level[0]` falls 6 edges after the release with a single `btn_fall[0]` pulse. Other channels stay 0.
- **Glitch:** `btn_in[1]` high for 3 cycles, then low → no change on any output.
- **Bounce:** `btn_in[2]` toggles every 2 cycles for 12 cycles, then stays 1 → exactly one `btn_rise[2]` pulse, occurring 6 edges after the final stable edge.
- **Reset mid-count:** `btn_in[3]` rises; assert `reset_n` 3 cycles later for 2 cycles → no pulse. With the button still held after release, `btn_rise[3]` fires 6 edges after release.
- **Simultaneous channels:** `btn_in[4]` rises on the same cycle that `btn_in[0]` falls (channel 0 previously pressed) → `btn_rise[4]` and `btn_fall[0]` pulse in the same cycle.
